// File: rtl/branch_pkg.sv
// Shared types and helpers for the gshare branch predictor.
//   ctr_t        : 2-bit saturating counter
//   SNT..ST      : counter encodings, strongly not-taken .. strongly taken
//   pht_state_t  : table controller state (INIT sweep / RUN)
//   sat_update() : counter increment/decrement, clamped at both ends
package branch_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } pht_state_t;

  function automatic ctr_t sat_update(ctr_t ctr, logic taken);
    ctr_t res;
    if (taken) begin
      res = (ctr == ST) ? ST : ctr_t'(ctr + 2'b01);
    end else begin
      res = (ctr == SNT) ? SNT : ctr_t'(ctr - 2'b01);
    end
    return res;
  endfunction

endpackage

// File: rtl/pht_ram.sv
// Counter storage for the pattern history table.
// Two synchronous read ports (fetch, update) and one write port.
// A read and a write to the same address in one cycle returns the old value.
//   clk                   : clock
//   rd_a_addr / rd_a_data : fetch read port, data valid the cycle after addr
//   rd_b_addr / rd_b_data : update read port, same timing
//   wr_en/wr_addr/wr_data : write port
module pht_ram
  import branch_pkg::*;
#(
  parameter int G_WIDTH = 9
) (
  input  logic           clk,
  input  logic [G_WIDTH:0] rd_a_addr,
  output ctr_t           rd_a_data,
  input  logic [G_WIDTH:0] rd_b_addr,
  output ctr_t           rd_b_data,
  input  logic           wr_en,
  input  logic [G_WIDTH:0] wr_addr,
  input  ctr_t           wr_data
);

  localparam int DEPTH = 1 << (G_WIDTH + 1);

  ctr_t mem [DEPTH];
  ctr_t rd_a_q;
  ctr_t rd_b_q;

  always_ff @(posedge clk) begin
    rd_a_q <= mem[rd_a_addr];
    rd_b_q <= mem[rd_b_addr];
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_a_data = rd_a_q;
  assign rd_b_data = rd_b_q;

endmodule

// File: rtl/gshare_pht.sv
// Gshare pattern history table with speculative/retired global history.
//   clk, resetN                   : clock, synchronous active-low reset
//   ready                         : init sweep finished, table in use
//   fetchValid, fetchPC           : prediction request
//   predValid, predTaken, predIndex : prediction one cycle after the request
//   resolveValid, resolveIndex,
//   resolveTaken, mispredict      : branch outcome, trains counter and history
//
// state | meaning
// ------+--------------------------------------------------------------
// INIT  | sweeping ptr over the table writing CTR_INIT, inputs ignored
// RUN   | predicting and training until the next reset
module gshare_pht
  import branch_pkg::*;
#(
  parameter int   G_WIDTH  = 9,
  parameter ctr_t CTR_INIT = WNT
) (
  input  logic             clk,
  input  logic             resetN,
  output logic             ready,
  input  logic             fetchValid,
  input  logic [G_WIDTH:0] fetchPC,
  output logic             predValid,
  output logic             predTaken,
  output logic [G_WIDTH:0] predIndex,
  input  logic             resolveValid,
  input  logic [G_WIDTH:0] resolveIndex,
  input  logic             resolveTaken,
  input  logic             mispredict
);

  pht_state_t       state_q, state_d;
  logic [G_WIDTH:0] ptr_q, ptr_d;
  logic [G_WIDTH:0] spec_ghr_q, spec_ghr_d;
  logic [G_WIDTH:0] ret_ghr_q, ret_ghr_d;
  logic             pred_valid_q, pred_valid_d;
  logic [G_WIDTH:0] pred_index_q, pred_index_d;
  logic             upd_valid_q, upd_valid_d;
  logic [G_WIDTH:0] upd_index_q, upd_index_d;
  logic             upd_taken_q, upd_taken_d;
  logic             fwd_hit_q, fwd_hit_d;
  ctr_t             fwd_val_q, fwd_val_d;

  logic             run;
  logic             repair;
  logic             fetch_accept;
  logic [G_WIDTH:0] fetch_idx;
  logic             pred_taken;
  ctr_t             rd_a_data, rd_b_data;
  ctr_t             upd_old, upd_new;
  logic             wr_en;
  logic [G_WIDTH:0] wr_addr;
  ctr_t             wr_data;

  pht_ram #(.G_WIDTH(G_WIDTH)) u_ram (
    .clk       (clk),
    .rd_a_addr (fetch_idx),
    .rd_a_data (rd_a_data),
    .rd_b_addr (resolveIndex),
    .rd_b_data (rd_b_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always_comb begin
    run          = (state_q == RUN);
    repair       = run && resolveValid && mispredict;
    fetch_accept = run && fetchValid && !repair;
    fetch_idx    = spec_ghr_q ^ fetchPC;
    pred_taken   = pred_valid_q && rd_a_data[1];

    // The RAM still holds the pre-write value when back-to-back resolves
    // hit the same entry, so take the result captured from stage 2 instead.
    upd_old = fwd_hit_q ? fwd_val_q : rd_b_data;
    upd_new = sat_update(upd_old, upd_taken_q);

    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    wr_addr = upd_index_q;
    wr_data = upd_new;

    case (state_q)
      INIT: begin
        wr_en   = resetN;
        wr_addr = ptr_q;
        wr_data = CTR_INIT;
        ptr_d   = ptr_q + 1'b1;
        if (ptr_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        wr_en = resetN && upd_valid_q;
      end
      default: begin
        state_d = INIT;
      end
    endcase

    pred_valid_d = fetch_accept;
    pred_index_d = fetch_accept ? fetch_idx : pred_index_q;

    upd_valid_d = run && resolveValid;
    upd_index_d = resolveIndex;
    upd_taken_d = resolveTaken;
    fwd_hit_d   = run && resolveValid && upd_valid_q && (resolveIndex == upd_index_q);
    fwd_val_d   = upd_new;

    ret_ghr_d = ret_ghr_q;
    if (run && resolveValid) begin
      ret_ghr_d = {ret_ghr_q[G_WIDTH-1:0], resolveTaken};
    end

    // Repair has priority: a prediction leaving the pipe in the repair
    // cycle belongs to the wrong path and must not enter history.
    spec_ghr_d = spec_ghr_q;
    if (repair) begin
      spec_ghr_d = {ret_ghr_q[G_WIDTH-1:0], resolveTaken};
    end else if (pred_valid_q) begin
      spec_ghr_d = {spec_ghr_q[G_WIDTH-1:0], pred_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q      <= INIT;
      ptr_q        <= '0;
      spec_ghr_q   <= '0;
      ret_ghr_q    <= '0;
      pred_valid_q <= 1'b0;
      pred_index_q <= '0;
      upd_valid_q  <= 1'b0;
      upd_index_q  <= '0;
      upd_taken_q  <= 1'b0;
      fwd_hit_q    <= 1'b0;
      fwd_val_q    <= SNT;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      spec_ghr_q   <= spec_ghr_d;
      ret_ghr_q    <= ret_ghr_d;
      pred_valid_q <= pred_valid_d;
      pred_index_q <= pred_index_d;
      upd_valid_q  <= upd_valid_d;
      upd_index_q  <= upd_index_d;
      upd_taken_q  <= upd_taken_d;
      fwd_hit_q    <= fwd_hit_d;
      fwd_val_q    <= fwd_val_d;
    end
  end

  assign ready     = run;
  assign predValid = pred_valid_q;
  assign predTaken = pred_taken;
  assign predIndex = pred_index_q;

endmodule

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
- Gshare pattern history table (PHT) that consumes the history-XOR-PC index.
- Holds 2^(G_WIDTH+1) 2-bit saturating counters and produces taken/not-taken predictions for fetch.
- Trains counters on branch resolution.
- Owns the speculative and retired global history registers, including repair on mispredict, so fetch sees a consistent index.

Parameters:
- G_WIDTH, 9, index MSB; index width G_WIDTH+1, table depth 2^(G_WIDTH+1) = 1024.
- CTR_INIT, 2'b01, counter value written by the reset sweep (weakly not-taken).

Ports:
- clk  in  1  clock, all state on posedge.
- resetN  in  1  synchronous active-low reset.
- ready  out  1  high once the init sweep completes; fetch/resolve are ignored while low.
- fetchValid  in  1  fetch is requesting a prediction this cycle.
- fetchPC  in  G_WIDTH+1  low PC bits of the fetched branch.
- predValid  out  1  prediction valid; asserted one cycle after an accepted fetch.
- predTaken  out  1  prediction, equal to counter bit 1.
- predIndex  out  G_WIDTH+1  index used; carried with the branch until resolve.
- resolveValid  in  1  branch resolved this cycle.
- resolveIndex  in  G_WIDTH+1  index returned from predIndex.
- resolveTaken  in  1  actual outcome.
- mispredict  in  1  qualifies resolveValid; triggers history repair.

Behaviour:
- Reset (resetN=0 at a clk edge):
  - ready=0, predValid=0, predTaken=0, predIndex=0.
  - specGHR=0, retGHR=0.
  - FSM enters INIT with sweep pointer 0.
  - Reset asserted mid-operation or mid-sweep restarts the sweep from 0 and drops any in-flight prediction or update.
- FSM states: INIT, RUN.
  - INIT: writes CTR_INIT to entry ptr each cycle, ptr++.
  - INIT -> RUN after writing entry 2^(G_WIDTH+1)-1, i.e. 1024 cycles after reset deasserts. ready goes high the cycle after the last write.
  - RUN: stays until reset.
- Predict (RUN only):
  - Fetch is accepted in cycle N if fetchValid && !(resolveValid && mispredict).
  - idx = specGHR(cycle N) ^ fetchPC.
  - Table read is synchronous: predValid=1, predTaken and predIndex=idx appear in cycle N+1.
  - predValid is a one-cycle pulse per accepted fetch. Back-to-back fetches give back-to-back predictions.
- Speculative history:
  - At the edge ending cycle N+1: specGHR <= {specGHR[G_WIDTH-1:0], predTaken}.
  - So a fetch in N+1 does not yet see prediction N. This is intended and must match the reference model.
- Retired history: on each resolveValid, retGHR <= {retGHR[G_WIDTH-1:0], resolveTaken}.
- Repair:
  - On resolveValid && mispredict: specGHR <= {retGHR[G_WIDTH-1:0], resolveTaken}.
  - Repair overrides the speculative shift in the same cycle.
  - A predValid in the repair cycle is still output but does not shift specGHR.
  - A fetch in the repair cycle is not accepted (no predValid next cycle).
- Counter update is a 2-stage read-modify-write:
  - Cycle R: read counter at resolveIndex.
  - Cycle R+1: write sat(ctr±1).
  - Taken increments and saturates at 2'b11; not-taken decrements and saturates at 2'b00.
  - Width stays 2 bits; no wrap permitted.
- Hazards:
  - Resolves to the same index in R and R+1: stage-1 must forward the pending stage-2 result, so two taken updates from 01 give 11.
  - Fetch read and update write to the same index in the same cycle: read returns the pre-write value.
  - Fetch and resolve in the same cycle with different indices proceed independently. The RAM has one read port for fetch, one read port for update, and one write port.

Decomposition:
- Package branch_pkg:
  - typedef ctr_t (logic[1:0]).
  - Constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - enum pht_state_t {INIT, RUN}.
  - Function sat_update(ctr_t, logic taken).
- Sub-module pht_ram: depth 2^(G_WIDTH+1), 2-bit wide, two synchronous read ports, one write port, read-before-write.
- FSM, history registers and forwarding stay in gshare_pht.

Test Plan:
- Init: hold resetN=0 2 cycles, release -> ready=0 for exactly 1024 cycles, then 1. First fetch PC=0x005 -> predValid next cycle, predTaken=0, predIndex=0x005.
- Saturation: resolve index 0x00A taken 4 times, spaced 3 cycles apart -> counter 01->10->11->11. A later fetch hitting 0x00A gives predTaken=1. Then 4 not-taken -> 00, predTaken=0.
- Forwarding: resolve index 0x3FF taken in consecutive cycles from 01 -> counter 11, not 10.
- History: 3 consecutive fetches from specGHR=0, PC=0, counter 0x000 forced to 11 -> predIndex sequence 0x000, 0x000, 0x001. specGHR=0x003 after the second prediction retires.
- Mispredict repair: retGHR=0x155, resolveValid&mispredict, resolveTaken=0, concurrent fetchValid -> specGHR=0x2AA next cycle, no predValid for that fetch.
- Reset mid-sweep and mid-update: assert resetN=0 at sweep pointer 500 with an update pending -> sweep restarts, ready low for a full 1024 cycles, all entries read back CTR_INIT.
